product_unloader: RTL and testbench

Reads a completed double-wide product back out one half at a time. It takes an N-bit word, such as a 16-bit product from the 8x8 multiplier datapath, over a valid/ready handshake and presents it on an N/2-bit output over a second valid/ready handshake. The halves go out in a parameter-selected order, and `out_last` flags the second half. It sits between the multiplier's double-wide product register and any byte-wide consumer (display driver, bus, bench monitor).

---
 rtl/mult_pkg.sv | 9 +
 rtl/product_unloader_if.sv | 26 ++
 rtl/product_unloader.sv | 67 ++++++
 tb/tb_product_unloader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier datapath and its product unloader.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} unload_state_t;

    localparam int PRODUCT_W = 16;
    localparam int COUNT_W   = 8;

endpackage

// File: rtl/product_unloader_if.sv
// Word-in / half-out handshake bundle for product_unloader.
interface product_unloader_if
    import mult_pkg::*;
#(
    parameter int N = PRODUCT_W
);
    logic [N-1:0]       in_word;
    logic               in_valid;
    logic               in_ready;
    logic [N/2-1:0]     out_half;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [COUNT_W-1:0] word_count;

    // slave: the unloader itself; master: the producer/consumer environment
    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_half, out_valid, out_last, word_count
    );

    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_half, out_valid, out_last, word_count
    );
endinterface

// File: rtl/product_unloader.sv
// Unloads a double-wide product as two half-width beats, order set by HIGH_FIRST,
// flagging the second beat with out_last and counting completed words.
module product_unloader
    import mult_pkg::*;
#(
    parameter int N          = PRODUCT_W,
    parameter int HIGH_FIRST = 1
) (
    input  logic                clk,
    input  logic                clear,
    product_unloader_if.slave   bus
);
    localparam int H = N / 2;

    unload_state_t      state_q, state_d;
    logic [N-1:0]       hold_q;
    logic [COUNT_W-1:0] count_q;
    logic [H-1:0]       half_d;
    logic               in_hs;
    logic               out_hs;

    // Accepting during SECOND only when the last half leaves lets words stream with no bubble.
    assign bus.in_ready   = (state_q == IDLE) || ((state_q == SECOND) && bus.out_ready);
    assign bus.out_valid  = (state_q != IDLE);
    assign bus.out_last   = (state_q == SECOND);
    assign bus.out_half   = half_d;
    assign bus.word_count = count_q;

    assign in_hs  = bus.in_valid && bus.in_ready;
    assign out_hs = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_hs)  state_d = FIRST;
            FIRST:   if (out_hs) state_d = SECOND;
            SECOND:  if (out_hs) state_d = in_hs ? FIRST : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        half_d = '0;
        case (state_q)
            FIRST:   half_d = (HIGH_FIRST != 0) ? hold_q[N-1:H] : hold_q[H-1:0];
            SECOND:  half_d = (HIGH_FIRST != 0) ? hold_q[H-1:0] : hold_q[N-1:H];
            default: half_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            hold_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (in_hs) begin
                hold_q <= bus.in_word;
            end
            if (out_hs && (state_q == SECOND)) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_product_unloader.sv
// Bench for product_unloader: directed scenarios plus random traffic against a
// queue-of-halves reference model.
module tb_product_unloader;
    import mult_pkg::*;

    logic clk   = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    product_unloader_if #(.N(PRODUCT_W)) bus  ();
    product_unloader_if #(.N(PRODUCT_W)) bus2 ();

    product_unloader #(.N(PRODUCT_W), .HIGH_FIRST(1)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    product_unloader #(.N(PRODUCT_W), .HIGH_FIRST(0)) dut_lo (
        .clk   (clk),
        .clear (clear),
        .bus   (bus2)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cnt_m    = 8'd0;
    int         guard;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input logic iv, input logic [15:0] iw, input logic ordy);
        logic       er, ev, el;
        logic [7:0] eh;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_word   = iw;
        bus.out_ready = ordy;
        ev = (exp_q.size() != 0);
        el = (exp_q.size() == 1);
        er = (exp_q.size() == 0) || ((exp_q.size() == 1) && ordy);
        eh = ev ? exp_q[0] : 8'h00;
        #1;
        check("in_ready",   {15'd0, bus.in_ready},  {15'd0, er});
        check("out_valid",  {15'd0, bus.out_valid}, {15'd0, ev});
        check("out_last",   {15'd0, bus.out_last},  {15'd0, el});
        check("out_half",   {8'd0, bus.out_half},   {8'd0, eh});
        check("word_count", {8'd0, bus.word_count}, {8'd0, cnt_m});
        if (ev && ordy) begin
            if (exp_q.size() == 1) cnt_m = cnt_m + 8'd1;
            exp_q.delete(0);
        end
        if (iv && er) begin
            exp_q.push_back(iw[15:8]);
            exp_q.push_back(iw[7:0]);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;
        exp_q.delete();
        cnt_m = 8'd0;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clr_in_ready",   {15'd0, bus.in_ready},  16'd1);
        check("clr_out_valid",  {15'd0, bus.out_valid}, 16'd0);
        check("clr_out_last",   {15'd0, bus.out_last},  16'd0);
        check("clr_out_half",   {8'd0, bus.out_half},   16'd0);
        check("clr_word_count", {8'd0, bus.word_count}, 16'd0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_word    = 16'h0000;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_word   = 16'h0000;
        bus2.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_clear();

        // High-half first: BEEF -> BE, EF(last), then count 1
        step(1'b1, 16'hBEEF, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        check("beef_first", {8'd0, bus.out_half}, 16'h00BE);
        step(1'b0, 16'h0000, 1'b1);
        check("beef_second", {8'd0, bus.out_half}, 16'h00EF);
        step(1'b0, 16'h0000, 1'b1);
        check("beef_count", {8'd0, bus.word_count}, 16'd1);

        // Low-half first instance: 1234 -> 34, 12(last)
        @(negedge clk);
        bus2.in_word   = 16'h1234;
        bus2.in_valid  = 1'b1;
        bus2.out_ready = 1'b1;
        #1 check("lo_in_ready", {15'd0, bus2.in_ready}, 16'd1);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        #1;
        check("lo_first_half", {8'd0, bus2.out_half}, 16'h0034);
        check("lo_first_last", {15'd0, bus2.out_last}, 16'd0);
        @(negedge clk);
        #1;
        check("lo_second_half", {8'd0, bus2.out_half}, 16'h0012);
        check("lo_second_last", {15'd0, bus2.out_last}, 16'd1);
        @(negedge clk);
        #1;
        check("lo_count", {8'd0, bus2.word_count}, 16'd1);
        check("lo_idle",  {15'd0, bus2.out_valid}, 16'd0);

        // Back-to-back words with in_valid held high
        step(1'b1, 16'hA1B2, 1'b1);
        step(1'b1, 16'hC3D4, 1'b1);
        step(1'b1, 16'hC3D4, 1'b1);
        check("b2b_in_ready_second", {15'd0, bus.in_ready}, 16'd1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);

        // Stall three cycles during FIRST
        step(1'b1, 16'h55AA, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h9999, 1'b0);
            check("stall_half", {8'd0, bus.out_half}, 16'h0055);
        end
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        check("stall_resume", {8'd0, bus.out_half}, 16'h00AA);
        step(1'b0, 16'h0000, 1'b1);

        // Clear while in SECOND discards the word
        step(1'b1, 16'hFACE, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        do_clear();
        step(1'b1, 16'h0F0F, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 9) < 7), 16'($urandom), logic'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1);

        // Counter wrap: 255 words, then the 256th returns to zero
        do_clear();
        guard = 0;
        while (cnt_m != 8'd255 && guard < 2000) begin
            step(1'b1, 16'($urandom), logic'($urandom_range(0, 3) != 0));
            guard++;
        end
        check("wrap_bound_255", {15'd0, guard < 2000}, 16'd1);
        step(1'b0, 16'h0000, 1'b0);
        check("wrap_255", {8'd0, bus.word_count}, 16'd255);
        guard = 0;
        while (cnt_m != 8'd0 && guard < 20) begin
            step(1'b1, 16'($urandom), 1'b1);
            guard++;
        end
        check("wrap_bound_0", {15'd0, guard < 20}, 16'd1);
        step(1'b0, 16'h0000, 1'b0);
        check("wrap_0", {8'd0, bus.word_count}, 16'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
